// File: rtl/updown_counter_pkg.sv
// Shared types and helpers for the modulus up/down counter.
// Holds the one-shot state encoding, mode codes and the step function.
package updown_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic WRAP    = 1'b0;
  localparam logic ONESHOT = 1'b1;

  // One modulo-m step in the requested direction.
  function automatic int unsigned next_val(
    input int unsigned q,
    input logic        up,
    input int unsigned m
  );
    if (up)
      return (q == m - 32'd1) ? 32'd0 : q + 32'd1;
    else
      return (q == 32'd0) ? m - 32'd1 : q - 32'd1;
  endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Synchronous modulus up/down counter with load, wrap and one-shot modes.
// Step datapath, one-shot FSM and registered terminal count in one place.
module updown_mod_counter
  import updown_counter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned MOD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         mode,
  input  logic         start,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         busy
);

  localparam logic [N:0]   MOD_W = (N+1)'(MOD);
  localparam logic [N-1:0] MAX_V = N'(MOD - 1);

  state_t       state;
  state_t       state_n;
  logic         mode_q;
  logic [N-1:0] q_n;
  logic [N-1:0] q_step;
  logic [N-1:0] tgt;
  logic [N-1:0] start_v;
  logic [N-1:0] ld_v;
  logic         tc_n;
  logic         wrap_hit;

  assign q_step   = N'(next_val(32'(q), up, MOD));
  assign tgt      = up ? MAX_V : '0;
  assign start_v  = up ? '0 : MAX_V;
  assign ld_v     = ({1'b0, din} < MOD_W) ? din : MAX_V;
  assign wrap_hit = up ? (q == MAX_V) : (q == '0);
  assign busy     = (state == RUN);

  // Next count, next state and terminal-count decision.
  always_comb begin
    q_n     = q;
    state_n = state;
    tc_n    = 1'b0;
    if (mode != mode_q) begin
      state_n = IDLE;
    end else if (load) begin
      q_n = ld_v;
    end else if (mode == WRAP) begin
      state_n = IDLE;
      if (en) begin
        q_n  = q_step;
        tc_n = wrap_hit;
      end
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            q_n     = start_v;
            state_n = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (q == tgt) begin
              state_n = DONE;
              tc_n    = 1'b1;
            end else begin
              q_n = q_step;
              if (q_step == tgt) begin
                state_n = DONE;
                tc_n    = 1'b1;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Count, FSM state, tc pulse and last-seen mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      tc     <= 1'b0;
      state  <= IDLE;
      mode_q <= WRAP;
    end else begin
      q      <= q_n;
      tc     <= tc_n;
      state  <= state_n;
      mode_q <= mode;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter at N=4, MOD=10.
// Driver queues hand-computed results; monitor pops and compares.
module tb_updown_mod_counter;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    string      nm;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b0;
  logic       up    = 1'b0;
  logic       load  = 1'b0;
  logic       mode  = 1'b0;
  logic       start = 1'b0;
  logic [3:0] din   = 4'd0;
  logic [3:0] q;
  logic       tc;
  logic       busy;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.N(4), .MOD(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up    (up),
    .load  (load),
    .din   (din),
    .mode  (mode),
    .start (start),
    .q     (q),
    .tc    (tc),
    .busy  (busy)
  );

  task automatic drive(input logic e, input logic u,
                       input logic l, input logic [3:0] d,
                       input logic m, input logic s);
    en    = e;
    up    = u;
    load  = l;
    din   = d;
    mode  = m;
    start = s;
  endtask

  task automatic push(input logic [3:0] eq, input logic et,
                      input logic eb, input string nm);
    exp_t x;
    x.q    = eq;
    x.tc   = et;
    x.busy = eb;
    x.nm   = nm;
    sb.push_back(x);
  endtask

  task automatic tick(input logic [3:0] eq, input logic et,
                      input logic eb, input string nm);
    @(posedge clk);
    #1;
    push(eq, et, eb, nm);
  endtask

  // Monitor: compare one queued result per output window.
  initial begin
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        checks++;
        if (q !== x.q || tc !== x.tc || busy !== x.busy) begin
          failures++;
          $display("FAIL %s: got q=%0d tc=%b busy=%b, want q=%0d tc=%b busy=%b",
                   x.nm, q, tc, busy, x.q, x.tc, x.busy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    drive(0, 0, 0, 4'd0, 0, 0);
    tick(4'd0, 0, 0, "reset_state");
    tick(4'd0, 0, 0, "reset_hold");
    rst = 1'b0;

    drive(1, 1, 0, 4'd0, 0, 0);
    for (int i = 1; i <= 9; i++) tick(4'(i), 0, 0, "wrap_up");
    tick(4'd0, 1, 0, "wrap_up_tc");
    for (int i = 1; i <= 6; i++) tick(4'(i), 0, 0, "wrap_up2");

    #6;
    push(4'd0, 0, 0, "async_rst");
    rst = 1'b1;
    tick(4'd0, 0, 0, "rst_held");
    rst = 1'b0;

    drive(1, 0, 0, 4'd0, 0, 0);
    tick(4'd9, 1, 0, "wrap_dn_tc");
    tick(4'd8, 0, 0, "wrap_dn");
    tick(4'd7, 0, 0, "wrap_dn");
    drive(1, 1, 0, 4'd0, 0, 0);
    tick(4'd8, 0, 0, "flip_up");
    tick(4'd9, 0, 0, "flip_up");
    tick(4'd0, 1, 0, "flip_up_tc");

    drive(0, 1, 1, 4'd12, 0, 0);
    tick(4'd9, 0, 0, "load_clamp");
    drive(1, 1, 1, 4'd3, 0, 0);
    tick(4'd3, 0, 0, "load_over_en");

    drive(0, 0, 0, 4'd0, 1, 0);
    tick(4'd3, 0, 0, "mode_chg_hold");
    drive(0, 0, 0, 4'd0, 1, 1);
    tick(4'd9, 0, 1, "os_start_dn");
    drive(1, 0, 0, 4'd0, 1, 0);
    for (int i = 8; i >= 1; i--) tick(4'(i), 0, 1, "os_run_dn");
    tick(4'd0, 1, 0, "os_tc");
    tick(4'd0, 0, 0, "os_done_hold");
    tick(4'd0, 0, 0, "os_done_hold2");
    drive(1, 0, 0, 4'd0, 1, 1);
    tick(4'd9, 0, 1, "os_restart");

    drive(0, 0, 0, 4'd0, 1, 0);
    tick(4'd9, 0, 1, "os_en0");
    drive(1, 0, 0, 4'd0, 1, 0);
    tick(4'd8, 0, 1, "os_en1");
    drive(0, 0, 0, 4'd0, 1, 0);
    tick(4'd8, 0, 1, "os_en0b");
    drive(1, 0, 0, 4'd0, 1, 1);
    tick(4'd7, 0, 1, "os_start_ign");

    drive(0, 1, 1, 4'd9, 1, 0);
    tick(4'd9, 0, 1, "os_load");
    drive(1, 1, 0, 4'd0, 1, 0);
    tick(4'd9, 1, 0, "os_load_done");
    tick(4'd9, 0, 0, "os_done_q");

    drive(0, 1, 0, 4'd0, 1, 1);
    tick(4'd0, 0, 1, "os_start_up");
    drive(1, 1, 0, 4'd0, 1, 0);
    tick(4'd1, 0, 1, "os_run_up");
    tick(4'd2, 0, 1, "os_run_up");
    drive(1, 1, 0, 4'd0, 0, 0);
    tick(4'd2, 0, 0, "mode_to_wrap");
    tick(4'd3, 0, 0, "wrap_resume");

    #10;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
